// File: rtl/word_memory.sv
// Parametrised scratch store: DEPTH words of WIDTH bits, byte-lane writes, registered
// read port with per-entry valid tracking and an occupancy count.
module word_memory #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int LANES = WIDTH / 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int UW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_be,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_hit,
  output logic [UW-1:0]    used
);

  localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic wr_ok;
  logic rd_entry_hit;

  // A dropped write (clear, empty lane mask, out-of-range index) must leave data, valid and used alone.
  assign wr_ok        = wr_en && !clear && ({1'b0, wr_addr} < DEPTH_LIM) && (|wr_be);
  assign rd_entry_hit = ({1'b0, rd_addr} < DEPTH_LIM) && valid[rd_addr];

  // NOTE: storage sits in a reset branch only because it must read back as zero after reset;
  // a plain scratch RAM would normally be left unreset so it can map onto memory macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_be[l]) mem[wr_addr][8*l +: 8] <= wr_data[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      used  <= '0;
    end else if (clear) begin
      valid <= '0;
      used  <= '0;
    end else if (wr_ok) begin
      valid[wr_addr] <= 1'b1;
      if (!valid[wr_addr]) used <= used + UW'(1);
    end
  end

  // NOTE: non-blocking updates above mean this block samples mem/valid as they were
  // before the edge, which is exactly the read-before-write behaviour on address collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_hit  <= rd_entry_hit;
        rd_data <= rd_entry_hit ? mem[rd_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_word_memory.sv
// Directed bench for word_memory: a 16-deep instance for the main behaviour and a
// 10-deep instance for out-of-range addressing and asynchronous reset during a read.
module tb_word_memory;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16-deep instance
  logic        a_clear, a_wr_en, a_rd_en, a_rd_valid, a_rd_hit;
  logic [3:0]  a_wr_addr, a_rd_addr, a_wr_be;
  logic [31:0] a_wr_data, a_rd_data;
  logic [4:0]  a_used;

  // 10-deep instance
  logic        b_clear, b_wr_en, b_rd_en, b_rd_valid, b_rd_hit;
  logic [3:0]  b_wr_addr, b_rd_addr, b_wr_be;
  logic [31:0] b_wr_data, b_rd_data;
  logic [3:0]  b_used;

  word_memory #(.WIDTH(32), .DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be), .wr_data(a_wr_data),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_hit(a_rd_hit), .used(a_used)
  );

  word_memory #(.WIDTH(32), .DEPTH(10)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_hit(b_rd_hit), .used(b_used)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_be = be; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic a_read(input string tag, input logic [3:0] addr,
                        input logic exp_hit, input logic [31:0] exp_data);
    a_rd_en = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_en = 1'b0;
    check({tag, ".valid"}, {31'b0, a_rd_valid}, 32'd1);
    check({tag, ".hit"},   {31'b0, a_rd_hit},   {31'b0, exp_hit});
    check({tag, ".data"},  a_rd_data,           exp_data);
  endtask

  initial begin
    a_clear = 0; a_wr_en = 0; a_rd_en = 0; a_wr_addr = 0; a_rd_addr = 0; a_wr_be = 0; a_wr_data = 0;
    b_clear = 0; b_wr_en = 0; b_rd_en = 0; b_wr_addr = 0; b_rd_addr = 0; b_wr_be = 0; b_wr_data = 0;

    // Reset held across two edges: everything reads zero.
    rst_n = 1'b0;
    tick(); tick();
    check("rst.rd_valid", {31'b0, a_rd_valid}, 32'd0);
    check("rst.rd_hit",   {31'b0, a_rd_hit},   32'd0);
    check("rst.rd_data",  a_rd_data,           32'd0);
    check("rst.used",     {27'b0, a_used},     32'd0);
    #2 rst_n = 1'b1;
    tick();

    // 1. Read of an empty entry.
    a_read("t1.rd3", 4'd3, 1'b0, 32'h0);
    check("t1.used", {27'b0, a_used}, 32'd0);
    tick();
    check("t1.idle_valid", {31'b0, a_rd_valid}, 32'd0);

    // 2. Full-word write then read; outputs hold once rd_en drops.
    a_write(4'd5, 4'hF, 32'hDEADBEEF);
    check("t2.used", {27'b0, a_used}, 32'd1);
    a_read("t2.rd5", 4'd5, 1'b1, 32'hDEADBEEF);
    tick();
    check("t2.hold_valid", {31'b0, a_rd_valid}, 32'd0);
    check("t2.hold_data",  a_rd_data,           32'hDEADBEEF);
    check("t2.hold_hit",   {31'b0, a_rd_hit},   32'd1);

    // 3. Partial-lane rewrite keeps disabled lanes; used unchanged on rewrite.
    a_write(4'd5, 4'b0101, 32'h11223344);
    check("t3.used", {27'b0, a_used}, 32'd1);
    a_read("t3.rd5", 4'd5, 1'b1, 32'hDE22BE44);

    // Empty lane mask is a no-op.
    a_write(4'd6, 4'h0, 32'hCAFEF00D);
    check("t3.be0_used", {27'b0, a_used}, 32'd1);
    a_read("t3.be0_rd6", 4'd6, 1'b0, 32'h0);

    // 4. Same-cycle read/write of an invalid entry returns old (empty) state.
    a_wr_en = 1; a_wr_addr = 4'd7; a_wr_be = 4'hF; a_wr_data = 32'hA5A5A5A5;
    a_rd_en = 1; a_rd_addr = 4'd7;
    tick();
    a_wr_en = 0; a_rd_en = 0;
    check("t4.col_valid", {31'b0, a_rd_valid}, 32'd1);
    check("t4.col_hit",   {31'b0, a_rd_hit},   32'd0);
    check("t4.col_data",  a_rd_data,           32'h0);
    check("t4.used",      {27'b0, a_used},     32'd2);
    a_read("t4.rd7", 4'd7, 1'b1, 32'hA5A5A5A5);

    // Same-cycle collision on a valid entry returns old data.
    a_wr_en = 1; a_wr_addr = 4'd5; a_wr_be = 4'hF; a_wr_data = 32'hFFFFFFFF;
    a_rd_en = 1; a_rd_addr = 4'd5;
    tick();
    a_wr_en = 0; a_rd_en = 0;
    check("t4.col5_hit",  {31'b0, a_rd_hit}, 32'd1);
    check("t4.col5_data", a_rd_data,         32'hDE22BE44);
    a_read("t4.rd5", 4'd5, 1'b1, 32'hFFFFFFFF);

    // 5. Fill every entry, rewrite one, then clear with a colliding write and a read.
    for (int i = 0; i < 16; i++) a_write(4'(i), 4'hF, 32'h10000000 + 32'(i));
    check("t5.full", {27'b0, a_used}, 32'd16);
    a_write(4'd15, 4'hF, 32'h2000000F);
    check("t5.full_rewrite", {27'b0, a_used}, 32'd16);
    a_clear = 1;
    a_wr_en = 1; a_wr_addr = 4'd0; a_wr_be = 4'hF; a_wr_data = 32'h77777777;
    a_rd_en = 1; a_rd_addr = 4'd5;
    tick();
    a_clear = 0; a_wr_en = 0; a_rd_en = 0;
    check("t5.clr_used",     {27'b0, a_used},     32'd0);
    check("t5.clr_rd_valid", {31'b0, a_rd_valid}, 32'd1);
    check("t5.clr_rd_hit",   {31'b0, a_rd_hit},   32'd1);
    check("t5.clr_rd_data",  a_rd_data,           32'h10000005);
    for (int i = 0; i < 16; i++) a_read($sformatf("t5.after_clr%0d", i), 4'(i), 1'b0, 32'h0);
    // Clear only invalidates: a single-lane write exposes the retained upper bytes.
    a_write(4'd2, 4'b0001, 32'h000000AA);
    check("t5.reuse_used", {27'b0, a_used}, 32'd1);
    a_read("t5.reuse_rd2", 4'd2, 1'b1, 32'h100000AA);

    // 6. DEPTH=10: out-of-range write/read, last legal entry.
    b_wr_en = 1; b_wr_addr = 4'd12; b_wr_be = 4'hF; b_wr_data = 32'h12121212;
    tick();
    b_wr_en = 0;
    check("t6.oor_used", {28'b0, b_used}, 32'd0);
    b_wr_en = 1; b_wr_addr = 4'd9; b_wr_be = 4'hF; b_wr_data = 32'h99999999;
    tick();
    b_wr_en = 0;
    check("t6.last_used", {28'b0, b_used}, 32'd1);
    b_rd_en = 1; b_rd_addr = 4'd12;
    tick();
    check("t6.oor_valid", {31'b0, b_rd_valid}, 32'd1);
    check("t6.oor_hit",   {31'b0, b_rd_hit},   32'd0);
    check("t6.oor_data",  b_rd_data,           32'h0);
    b_rd_addr = 4'd9;
    tick();
    check("t6.rd9_hit",  {31'b0, b_rd_hit}, 32'd1);
    check("t6.rd9_data", b_rd_data,         32'h99999999);

    // Reset asserted mid-read with rd_en still high: outputs drop without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_valid", {31'b0, b_rd_valid}, 32'd0);
    check("t6.rst_data",  b_rd_data,           32'h0);
    check("t6.rst_used",  {28'b0, b_used},     32'd0);
    check("t6.rst_a_used", {27'b0, a_used},    32'd0);
    b_rd_en = 0;
    #3 rst_n = 1'b1;
    tick();
    check("t6.post_valid", {31'b0, b_rd_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
